// File: rtl/shift_register_universal.sv
// Universal shift register: hold, logical/arithmetic shift, rotate, parallel load,
// plus a self-timed burst serializer that shifts a loaded word out on s_out.
module shift_register_universal #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enb,
   input  logic             dir,
   input  logic             s_in,
   input  logic [2:0]       mode,
   input  logic             start,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             s_out,
   output logic             busy,
   output logic             done
);
   // state | meaning
   // IDLE  | execute mode on every enabled cycle
   // SHIFT | burst: shift WIDTH bits toward dir_l; mode/start/d/dir ignored
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] M_SHIFT = 3'b001;
   localparam logic [2:0] M_ROT   = 3'b010;
   localparam logic [2:0] M_LOAD  = 3'b011;
   localparam logic [2:0] M_ASH   = 3'b100;
   localparam logic [2:0] M_BURST = 3'b101;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             dir_l, dir_l_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             s_out_nxt, done_nxt;

   logic             sh_dir, sh_fill, sh_out;
   logic [WIDTH-1:0] sh_q;

   // one shifter serves every mode; only direction and fill bit differ
   always_comb begin
      sh_dir  = (state == SHIFT) ? dir_l : dir;
      sh_fill = s_in;
      if (state == IDLE) begin
         case (mode)
            M_ROT:   sh_fill = dir ? q[WIDTH-1] : q[0];
            M_ASH:   sh_fill = dir ? 1'b0 : q[WIDTH-1];
            default: sh_fill = s_in;
         endcase
      end
   end

   assign sh_q   = sh_dir ? {q[WIDTH-2:0], sh_fill} : {sh_fill, q[WIDTH-1:1]};
   assign sh_out = sh_dir ? q[WIDTH-1] : q[0];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dir_l_nxt = dir_l;
      q_nxt     = q;
      s_out_nxt = s_out;
      done_nxt  = 1'b0;
      if (enb) begin
         case (state)
            IDLE: begin
               case (mode)
                  M_SHIFT, M_ROT, M_ASH: begin
                     q_nxt     = sh_q;
                     s_out_nxt = sh_out;
                  end
                  M_LOAD: q_nxt = d;
                  M_BURST: begin
                     if (start) begin
                        q_nxt     = d;
                        dir_l_nxt = dir;
                        cnt_nxt   = CW'(WIDTH);
                        state_nxt = SHIFT;
                     end
                  end
                  default: ;
               endcase
            end
            SHIFT: begin
               q_nxt     = sh_q;
               s_out_nxt = sh_out;
               cnt_nxt   = cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // done is rewritten every edge so it can never outlive its single cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         dir_l <= 1'b0;
         q     <= '0;
         s_out <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         dir_l <= dir_l_nxt;
         q     <= q_nxt;
         s_out <= s_out_nxt;
         busy  <= (state_nxt == SHIFT);
         done  <= done_nxt;
      end
   end

endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for shift_register_universal: table of single-cycle operations at WIDTH=8,
// hand-written burst, stall, back-to-back and abort sequences, and WIDTH=2/16 bursts.
module tb_shift_register_universal;

   typedef struct {
      logic       enb;
      logic [2:0] mode;
      logic       dir;
      logic       s_in;
      logic [7:0] d;
      logic [7:0] eq;
      logic       es;
   } vec_t;

   int total = 0;
   int bad   = 0;

   logic clk = 1'b0;
   logic reset;

   logic       enb, dir, s_in, start;
   logic [2:0] mode;
   logic [7:0] d, q;
   logic       s_out, busy, done;

   logic        enb_2, dir_2, s_in_2, start_2;
   logic [2:0]  mode_2;
   logic [1:0]  d_2, q_2;
   logic        s_out_2, busy_2, done_2;

   logic        enb_16, dir_16, s_in_16, start_16;
   logic [2:0]  mode_16;
   logic [15:0] d_16, q_16;
   logic        s_out_16, busy_16, done_16;

   vec_t vecs[16];

   always #5 clk = ~clk;

   shift_register_universal #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .enb(enb), .dir(dir), .s_in(s_in), .mode(mode),
      .start(start), .d(d), .q(q), .s_out(s_out), .busy(busy), .done(done)
   );

   shift_register_universal #(.WIDTH(2)) dut_2 (
      .clk(clk), .reset(reset), .enb(enb_2), .dir(dir_2), .s_in(s_in_2), .mode(mode_2),
      .start(start_2), .d(d_2), .q(q_2), .s_out(s_out_2), .busy(busy_2), .done(done_2)
   );

   shift_register_universal #(.WIDTH(16)) dut_16 (
      .clk(clk), .reset(reset), .enb(enb_16), .dir(dir_16), .s_in(s_in_16), .mode(mode_16),
      .start(start_16), .d(d_16), .q(q_16), .s_out(s_out_16), .busy(busy_16), .done(done_16)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // abort_after > 0 asserts reset asynchronously after that many shifts
   task automatic run_burst(input logic [7:0] data, input logic dv,
                            input int stall_at, input int stall_n, input int abort_after);
      logic [7:0] m;
      logic       exp_out;
      m       = data;
      exp_out = 1'b0;
      enb = 1'b1; mode = 3'b101; start = 1'b1; dir = dv; d = data; s_in = 1'b0;
      step();
      chk("burst_start_q", q, data);
      chk("burst_start_busy", busy, 1);
      chk("burst_start_done", done, 0);
      for (int k = 1; k <= 8; k++) begin
         if (k == stall_at) begin
            for (int s = 0; s < stall_n; s++) begin
               enb = 1'b0; mode = 3'($urandom_range(0, 7)); dir = ~dv; start = 1'b1;
               d = 8'($urandom);
               step();
               chk("stall_q", q, m);
               chk("stall_s_out", s_out, exp_out);
               chk("stall_busy", busy, 1);
               chk("stall_done", done, 0);
            end
         end
         enb = 1'b1; mode = 3'($urandom_range(0, 7)); dir = ~dv;
         start = 1'($urandom); d = 8'($urandom); s_in = 1'b0;
         exp_out = dv ? m[7] : m[0];
         m = dv ? {m[6:0], 1'b0} : {1'b0, m[7:1]};
         step();
         chk("burst_s_out", s_out, exp_out);
         chk("burst_q", q, m);
         chk("burst_busy", busy, (k < 8) ? 1 : 0);
         chk("burst_done", done, (k == 8) ? 1 : 0);
         if (k == abort_after) begin
            #2 reset = 1'b1;
            #1;
            chk("abort_q", q, 0);
            chk("abort_s_out", s_out, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            return;
         end
      end
      mode = 3'b000; start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] m16;
      logic        e16;
      int          edges;

      vecs[0]  = '{1'b0, 3'b011, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0};
      vecs[1]  = '{1'b1, 3'b011, 1'b0, 1'b0, 8'hB3, 8'hB3, 1'b0};
      vecs[2]  = '{1'b1, 3'b010, 1'b1, 1'b0, 8'h00, 8'h67, 1'b1};
      vecs[3]  = '{1'b1, 3'b001, 1'b0, 1'b1, 8'h00, 8'hB3, 1'b1};
      vecs[4]  = '{1'b0, 3'b011, 1'b0, 1'b0, 8'h00, 8'hB3, 1'b1};
      vecs[5]  = '{1'b1, 3'b110, 1'b1, 1'b1, 8'h00, 8'hB3, 1'b1};
      vecs[6]  = '{1'b1, 3'b111, 1'b0, 1'b1, 8'h00, 8'hB3, 1'b1};
      vecs[7]  = '{1'b1, 3'b101, 1'b1, 1'b1, 8'h00, 8'hB3, 1'b1};
      vecs[8]  = '{1'b1, 3'b011, 1'b0, 1'b0, 8'h84, 8'h84, 1'b1};
      vecs[9]  = '{1'b1, 3'b100, 1'b0, 1'b0, 8'h00, 8'hC2, 1'b0};
      vecs[10] = '{1'b1, 3'b100, 1'b0, 1'b1, 8'h00, 8'hE1, 1'b0};
      vecs[11] = '{1'b1, 3'b100, 1'b1, 1'b0, 8'h00, 8'hC2, 1'b1};
      vecs[12] = '{1'b1, 3'b001, 1'b1, 1'b1, 8'h00, 8'h85, 1'b1};
      vecs[13] = '{1'b1, 3'b010, 1'b0, 1'b0, 8'h00, 8'hC2, 1'b1};
      vecs[14] = '{1'b1, 3'b100, 1'b1, 1'b1, 8'h00, 8'h84, 1'b1};
      vecs[15] = '{1'b1, 3'b001, 1'b0, 1'b0, 8'h00, 8'h42, 1'b0};

      reset = 1'b1;
      enb = 1'b0; dir = 1'b0; s_in = 1'b0; start = 1'b0; mode = 3'b000; d = 8'h00;
      enb_2 = 1'b1; dir_2 = 1'b0; s_in_2 = 1'b0; start_2 = 1'b0; mode_2 = 3'b000; d_2 = 2'b00;
      enb_16 = 1'b1; dir_16 = 1'b0; s_in_16 = 1'b0; start_16 = 1'b0; mode_16 = 3'b000;
      d_16 = 16'h0000;
      step();
      step();
      chk("reset_q", q, 0);
      chk("reset_s_out", s_out, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_q16", q_16, 0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         enb = vecs[i].enb; mode = vecs[i].mode; dir = vecs[i].dir;
         s_in = vecs[i].s_in; d = vecs[i].d; start = 1'b0;
         step();
         chk($sformatf("vec%0d_q", i), q, vecs[i].eq);
         chk($sformatf("vec%0d_s_out", i), s_out, vecs[i].es);
         chk($sformatf("vec%0d_busy", i), busy, 0);
         chk($sformatf("vec%0d_done", i), done, 0);
      end

      // MSB-first burst, then a back-to-back LSB-first burst with a 3-cycle stall
      run_burst(8'hCA, 1'b1, 0, 0, 0);
      run_burst(8'h0F, 1'b0, 4, 3, 0);
      enb = 1'b1; mode = 3'b000; start = 1'b0;
      step();
      chk("after_done_done", done, 0);
      chk("after_done_q", q, 0);

      run_burst(8'h5A, 1'b1, 0, 0, 4);
      step();
      step();
      chk("in_reset_q", q, 0);
      reset = 1'b0;
      enb = 1'b1; mode = 3'b000; start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("post_abort_done", done, 0);
         chk("post_abort_busy", busy, 0);
      end

      // WIDTH=2, LSB first
      mode_2 = 3'b101; start_2 = 1'b1; dir_2 = 1'b0; d_2 = 2'b10;
      step();
      chk("w2_start_q", q_2, 2'b10);
      chk("w2_start_busy", busy_2, 1);
      mode_2 = 3'b011; start_2 = 1'b0; dir_2 = 1'b1; d_2 = 2'b11;
      step();
      chk("w2_s_out1", s_out_2, 0);
      chk("w2_busy1", busy_2, 1);
      step();
      chk("w2_s_out2", s_out_2, 1);
      chk("w2_q2", q_2, 0);
      chk("w2_busy2", busy_2, 0);
      chk("w2_done2", done_2, 1);
      mode_2 = 3'b000;
      step();
      chk("w2_done3", done_2, 0);

      // WIDTH=16, MSB first; done must rise on the 17th edge
      mode_16 = 3'b101; start_16 = 1'b1; dir_16 = 1'b1; d_16 = 16'hA5C3;
      m16 = 16'hA5C3;
      edges = 0;
      for (int e = 1; e <= 40; e++) begin
         step();
         edges = e;
         mode_16 = 3'b010; start_16 = 1'b0; dir_16 = 1'b0;
         if (e >= 2) begin
            e16 = m16[15];
            m16 = {m16[14:0], 1'b0};
            chk("w16_s_out", s_out_16, e16);
         end
         if (done_16) break;
      end
      chk("w16_done_edge", edges, 17);
      chk("w16_q", q_16, 0);
      mode_16 = 3'b011; d_16 = 16'h1234;
      step();
      chk("w16_load", q_16, 16'h1234);
      chk("w16_done_low", done_16, 0);
      mode_16 = 3'b110; d_16 = 16'hFFFF;
      step();
      chk("w16_rsv110", q_16, 16'h1234);
      mode_16 = 3'b111;
      step();
      chk("w16_rsv111", q_16, 16'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_register_universal.md
# shift_register_universal

- Parametrised universal shift register, successor to the 4-bit desplazador.
- Register width is set by `WIDTH`.
- Adds arithmetic shift, a registered serial output and a self-timed burst-serialize mode (load, then shift out `WIDTH` bits autonomously with `BUSY`/`DONE` status).
- Sits between the parallel datapath and serial links; runs in the single `CLK` domain.

## Interface
- `WIDTH`, 8, register width in bits; legal range ≥ 2.
- `CLK` input 1: clock; all state changes on the rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `ENB` input 1: clock enable; when 0, all state holds (including burst progress).
- `DIR` input 1:
  - 1 = shift left (toward MSB); the incoming bit enters bit 0 and bit `WIDTH-1` leaves.
  - 0 = shift right; the incoming bit enters bit `WIDTH-1` and bit 0 leaves.
- `S_IN` input 1: serial input bit.
- `MODE` input 3: operation select, see Operation.
- `START` input 1: burst request; only meaningful with `MODE`=101.
- `D` input `WIDTH`: parallel load data.
- `Q` output `WIDTH`: register contents.
- `S_OUT` output 1: registered copy of the last bit shifted or rotated out.
- `BUSY` output 1: high while a burst is in progress.
- `DONE` output 1: one-cycle pulse after the final burst shift.

## Operation
- Reset values: `Q`=0, `S_OUT`=0, `BUSY`=0, `DONE`=0, FSM=IDLE, bit counter=0.
- FSM states:
  - IDLE: executes `MODE` each cycle `ENB`=1.
  - SHIFT: burst in progress; `MODE`, `START`, `D` and live `DIR` are ignored.
- `MODE` encoding in IDLE, with `ENB`=1:
  - 000 hold.
  - 001 logical shift in `DIR`, filled from `S_IN`; `S_OUT` ← outgoing bit.
  - 010 rotate in `DIR`; the outgoing bit re-enters the opposite end; `S_OUT` ← outgoing bit.
  - 011 parallel load `Q` ← `D`; `S_OUT` holds.
  - 100 arithmetic shift:
    - right replicates `Q[WIDTH-1]`;
    - left fills 0;
    - `S_IN` ignored; `S_OUT` ← outgoing bit.
  - 101 with `START`=1: `Q` ← `D`, latch `DIR` into `dir_l`, counter ← `WIDTH`, go to SHIFT.
  - 101 with `START`=0: hold.
  - 110, 111: hold (reserved).
- SHIFT, `ENB`=1: logical shift in `dir_l` filled from `S_IN`, `S_OUT` ← outgoing bit, counter decrements.
  - When the shift taken with counter=1 completes, go to IDLE and assert `DONE` for the following cycle.
- SHIFT, `ENB`=0: full stall; counter, `Q` and `S_OUT` hold.
- `BUSY` = (state == SHIFT), registered.
- `DONE` is registered.
  - It is high only in the single cycle after the final shift edge.
  - It is forced low in every other cycle, including when `ENB`=0 on the next edge.
- Counter width is `$clog2(WIDTH+1)` bits; no wrap, since it never decrements below 0.

## Timing
- All non-burst modes have 1-cycle latency: the result appears on `Q`/`S_OUT` after the enabled edge.
- Burst timeline, start accepted at enabled edge N:
  - After N: `Q`=`D`, `BUSY`=1.
  - After the k-th subsequent enabled edge (k = 1..`WIDTH`): `S_OUT` = the k-th bit of the loaded word in shift order.
    - `dir_l`=1: MSB first.
    - `dir_l`=0: LSB first.
  - After the `WIDTH`-th shift edge: `BUSY`=0 and `DONE`=1 for exactly one cycle.
- Back-to-back bursts: `START` with `MODE`=101 in the `DONE` cycle is accepted (state is IDLE); `DONE` still drops after that edge.
- Burst duration is `WIDTH`+1 enabled edges, stretched one edge per `ENB`=0 cycle.
- `RESET` asserted at any time, including mid-burst, immediately clears all state and outputs to reset values, independent of `CLK`.
- Deassertion is synchronous to the next rising edge in practice; the first operation is taken on the first edge with `RESET` low.

## Test plan
- Reset, `WIDTH`=8: drive `RESET`=1 mid-run → `Q`=00000000, `S_OUT`=0, `BUSY`=0, `DONE`=0 before any clock edge; all hold while `ENB`=0.
- Load/shift/rotate:
  - Load 10110011 (`MODE`=011).
  - Rotate left (010, `DIR`=1) → `Q`=01100111, `S_OUT`=1.
  - Logical right (001, `DIR`=0, `S_IN`=1) → `Q`=10110011, `S_OUT`=1.
- Arithmetic:
  - Load 10000100, `MODE`=100, `DIR`=0, two edges → `Q`=11100001, `S_OUT`=0.
  - Then `DIR`=1 → `Q`=11000010, `S_OUT`=1.
- Burst:
  - Start: `D`=11001010, `DIR`=1, `MODE`=101, `START`=1.
  - Toggle `MODE`/`DIR` during the burst (must be ignored).
  - Required: `S_OUT` sequence 1,1,0,0,1,0,1,0; `BUSY` high for 8 cycles; `DONE` one pulse; `Q`=00000000 with `S_IN`=0.
- Burst stall and reset:
  - Insert 3 `ENB`=0 cycles mid-burst → `DONE` delayed by exactly 3 cycles, sequence unchanged.
  - Assert `RESET` after 4 shifts → `BUSY`=0, `DONE` never pulses.
- Parametrisation: repeat the burst at `WIDTH`=2 (`D`=10, `DIR`=0 → `S_OUT` 0,1) and `WIDTH`=16 (17 edges to `DONE`); reserved `MODE` 110/111 → `Q` unchanged.
